// File: rtl/z80_wait_controller_if.sv
// Bus-side signal bundle of the Z80 wait-state controller: register-file access,
// Z80 cycle-type strobes, decoded device slot and the WAIT line.
interface z80_wait_controller_if #(
   parameter int N_DEV = 8
);
   localparam int AW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

   logic          i_cs_n;
   logic          i_wr_n;
   logic          i_rd_n;
   logic [AW-1:0] i_addr;
   logic [7:0]    i_data;
   logic [7:0]    o_data;
   logic          i_mreq_n;
   logic          i_iorq_n;
   logic          i_m1_n;
   logic          i_rfsh_n;
   logic [AW-1:0] i_device;
   logic          i_ext_wait_n;
   logic          o_wait_n;

   modport master (
      output i_cs_n, i_wr_n, i_rd_n, i_addr, i_data,
      output i_mreq_n, i_iorq_n, i_m1_n, i_rfsh_n, i_device, i_ext_wait_n,
      input  o_data, o_wait_n
   );

   modport slave (
      input  i_cs_n, i_wr_n, i_rd_n, i_addr, i_data,
      input  i_mreq_n, i_iorq_n, i_m1_n, i_rfsh_n, i_device, i_ext_wait_n,
      output o_data, o_wait_n
   );
endinterface

// File: rtl/z80_wait_controller.sv
// Programmable per-device wait-state generator for a Z80 bus: a small register
// file of wait counts and a down-counter that holds WAIT low after each new request.
module z80_wait_controller #(
   parameter int N_DEV  = 8,
   parameter int WS_W   = 4,
   parameter int DEF_WS = 0
) (
   input logic                  i_clk,
   input logic                  i_reset,
   z80_wait_controller_if.slave bus
);
   localparam int AW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

   logic [WS_W-1:0] ws [N_DEV];
   logic [WS_W-1:0] cnt;
   logic            req;
   logic            req_q;
   logic            trig;
   logic            reg_wr;
   logic            reg_rd;
   logic            cnt_nz;
   logic [7:0]      rd_data;
   logic            unused_data;

   // Cycle classification and register-strobe decode
   always_comb begin
      req    = (~bus.i_mreq_n & bus.i_rfsh_n) | (~bus.i_iorq_n & bus.i_m1_n);
      trig   = req & ~req_q;
      reg_wr = ~bus.i_cs_n & ~bus.i_wr_n;
      reg_rd = ~bus.i_cs_n & ~bus.i_rd_n;
      cnt_nz = (cnt != {WS_W{1'b0}});
   end

   // Wait-count register file; writes are locked out while reset is held
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < N_DEV; k++) begin
            ws[k] <= WS_W'(DEF_WS);
         end
      end else if (reg_wr) begin
         ws[bus.i_addr] <= bus.i_data[WS_W-1:0];
      end
   end

   // Request edge detector and wait down-counter; a same-edge write to the slot
   // is not yet visible here, so the count loads from the old value.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         req_q <= 1'b1;
         cnt   <= {WS_W{1'b0}};
      end else begin
         req_q <= req;
         if (trig) begin
            cnt <= ws[bus.i_device];
         end else if (cnt_nz && req) begin
            cnt <= cnt - WS_W'(1);
         end else if (!req) begin
            cnt <= {WS_W{1'b0}};
         end
      end
   end

   // Register readback, zero-extended to the 8-bit data bus
   always_comb begin
      rd_data = 8'h00;
      if (reg_rd) begin
         rd_data[WS_W-1:0] = ws[bus.i_addr];
      end else begin
         rd_data = 8'h00;
      end
   end

   assign unused_data  = ^bus.i_data;
   assign bus.o_data   = rd_data;
   assign bus.o_wait_n = ~(req & cnt_nz) & bus.i_ext_wait_n;

   if (AW < 1 || WS_W < 1 || WS_W > 8) begin : g_param_check
      $error("z80_wait_controller: unsupported parameter values");
   end
endmodule

// File: doc/z80_wait_controller.md
Z80_WAIT_CONTROLLER -- requirements
Module: z80_wait_controller

Interface
REQ-001 SHALL have parameter N_DEV, default 8: number of device slots (power of 2, 2..16).
REQ-002 SHALL have parameter WS_W, default 4: wait-count width in bits (1..8).
REQ-003 SHALL have parameter DEF_WS, default 0: per-slot wait count loaded at reset.
REQ-004 SHALL have port i_clk, input, 1: Z80 system clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_cs_n, input, 1: register-file select, active-low.
REQ-007 SHALL have port i_wr_n, input, 1: register write strobe, active-low.
REQ-008 SHALL have port i_rd_n, input, 1: register read strobe, active-low.
REQ-009 SHALL have port i_addr, input, clog2(N_DEV): slot index for register access.
REQ-010 SHALL have port i_data, input, 8: write data.
REQ-011 SHALL have port o_data, output, 8: read data.
REQ-012 SHALL have port i_mreq_n, input, 1: Z80 memory request, active-low.
REQ-013 SHALL have port i_iorq_n, input, 1: Z80 I/O request, active-low.
REQ-014 SHALL have port i_m1_n, input, 1: Z80 M1, active-low.
REQ-015 SHALL have port i_rfsh_n, input, 1: Z80 refresh, active-low.
REQ-016 SHALL have port i_device, input, clog2(N_DEV): decoded slot of the current bus cycle.
REQ-017 SHALL have port i_ext_wait_n, input, 1: external wait request, active-low.
REQ-018 SHALL have port o_wait_n, output, 1: Z80 WAIT, active-low.

Function
REQ-019 SHALL hold N_DEV wait registers ws[k] of WS_W bits each.
REQ-020 SHALL, on each rising edge with i_cs_n=0 and i_wr_n=0, write ws[i_addr] <= i_data[WS_W-1:0]; upper data bits are ignored.
REQ-021 SHALL drive o_data combinationally as {zeros, ws[i_addr]} when i_cs_n=0 and i_rd_n=0, else 8'h00.
REQ-022 SHALL define req = (~i_mreq_n & i_rfsh_n) | (~i_iorq_n & i_m1_n); refresh and interrupt-acknowledge cycles never generate internal waits.
REQ-023 SHALL register req once per clock as req_q; trig = req & ~req_q.
REQ-024 SHALL run a WS_W-bit down-counter cnt: on trig, cnt <= ws[i_device]; else if cnt != 0 and req, cnt <= cnt-1; else if ~req, cnt <= 0.
REQ-025 SHALL drive o_wait_n = ~(req & (cnt != 0)) & i_ext_wait_n; internal wait lasts exactly ws[i_device] clock cycles after the trigger edge, and ws=0 inserts none.
REQ-026 SHALL, on a simultaneous trig and register write to the same slot, load cnt from the old ws value; the new value applies from the next request.
REQ-027 SHALL, when req deasserts mid-count, release o_wait_n in the same cycle (combinational) and clear cnt on the next edge.
REQ-028 SHALL sample i_device only at the trig edge; later changes do not alter the count in progress.
REQ-029 SHALL pass i_ext_wait_n through unconditionally, including while cnt=0, during refresh and during reset.
REQ-030 SHALL fix the maximum internal wait at 2^WS_W-1 cycles; no wrap-around occurs because decrement stops at 0.

Reset
REQ-031 SHALL, while i_reset=1, force cnt=0, req_q=1 and ws[k]=DEF_WS for all k, and block register writes.
REQ-032 SHALL present o_wait_n=i_ext_wait_n and o_data=8'h00 (strobes idle) during and immediately after reset.
REQ-033 SHALL, because req_q resets to 1, not trigger on a request already active when reset releases; the first trigger requires a high-to-low request transition.

Verification
REQ-034 SHALL cover: write ws[3]=5, IORQ cycle with i_device=3 and M1 high -> o_wait_n low for exactly 5 clocks after the trig edge, then high.
REQ-035 SHALL cover: ws[2]=4, MREQ with i_rfsh_n=0 -> o_wait_n stays high; same MREQ with i_rfsh_n=1 -> 4 wait cycles.
REQ-036 SHALL cover: IORQ with M1 low (intack) and ws=7 -> no internal wait; i_ext_wait_n=0 -> o_wait_n=0.
REQ-037 SHALL cover: trig and write ws[1]=2 in the same cycle with old ws[1]=6 -> 6 wait cycles now, 2 wait cycles on the next request; readback returns 8'h02.
REQ-038 SHALL cover: ws=9, request released after 3 wait cycles -> o_wait_n high the same cycle, cnt=0 next edge.
REQ-039 SHALL cover: assert i_reset mid-wait with a count of 8 -> o_wait_n high immediately, all ws read back as DEF_WS, and no trigger until the request deasserts and reasserts.
